// File: rtl/uart_rx_ovs.sv
// UART receiver driven by a 16x (OVS) oversampling tick from uart_baudgen.
// Optional parity check is enabled with `define UART_RX_PARITY_EN.
module uart_rx_ovs #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
`ifdef UART_RX_PARITY_EN
    input  logic            parity_odd,
    output logic            parity_err,
`endif
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done,
    output logic            frame_err,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [5:0] S_HALF = 6'(OVS / 2 - 1);
    localparam logic [5:0] S_BIT  = 6'(OVS - 1);
    localparam logic [5:0] S_STOP = 6'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    state_t            state;
    logic [5:0]        s;
    logic [2:0]        n;
    logic [DBIT-1:0]   shreg;
    logic              rx_m;
    logic              rx_s;
`ifdef UART_RX_PARITY_EN
    logic              pbit;
`endif

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM: mid-bit sampling, LSB first, registered strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            shreg     <= '0;
            rx_dout   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_HALF) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 3'd1;
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            pbit  <= rx_s;
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            rx_dout   <= shreg;
                            rx_done   <= 1'b1;
                            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= ((^shreg) ^ pbit) != parity_odd;
`endif
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Testbench for uart_rx_ovs: directed frames, scoreboard of expected words.
// Parity scenarios are compiled in only with `define UART_RX_PARITY_EN.
module tb_uart_rx_ovs;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_tick = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_done;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd = 1'b0;
    logic       parity_err;
`endif

    uart_rx_ovs #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_tick     (s_tick),
        .rx         (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .rx_dout    (rx_dout),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         t0;
        bit         cl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   half = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) s_tick = half ? ~s_tick : 1'b1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_bit(logic v, int cnt);
        rx = v;
        repeat (cnt) @(negedge clk);
    endtask

    task automatic send(logic [7:0] d, logic stopv, logic pbit, logic pe,
                        int bt, bit cl);
        exp_t e;
        e.d  = d;
        e.fe = ~stopv;
        e.pe = pe;
        e.t0 = cyc;
        e.cl = cl;
        sb.push_back(e);
        put_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) put_bit(d[i], bt);
`ifdef UART_RX_PARITY_EN
        put_bit(pbit, bt);
`endif
        put_bit(stopv, bt);
    endtask

    always @(negedge clk) begin
        if (reset && rx_done) begin
            exp_t e;
            chk("done_pulse_width", prev_done, 1'b0);
            chk("unexpected_done", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rx_dout", rx_dout, e.d);
                chk("frame_err", frame_err, e.fe);
`ifdef UART_RX_PARITY_EN
                chk("parity_err", parity_err, e.pe);
`endif
                if (e.cl) begin
                    checks++;
                    assert ((cyc - e.t0) >= 154 && (cyc - e.t0) <= 156)
                    else begin
                        errors++;
                        $error("FAIL latency: observed %0d expected 155",
                               cyc - e.t0);
                    end
                end
            end
        end else if (reset) begin
            chk("frame_err_idle", frame_err, 1'b0);
        end
        prev_done = rx_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", rx_dout, 8'h00);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, 1'b0, 16, 1'b1);
        put_bit(1'b1, 20);
        chk("idle_after_a5", busy, 1'b0);

        put_bit(1'b0, 4);
        chk("glitch_busy_start", busy, 1'b1);
        put_bit(1'b1, 30);
        chk("glitch_busy_end", busy, 1'b0);
        chk("glitch_dout_held", rx_dout, 8'hA5);

        send(8'h3C, 1'b0, 1'b0, 1'b0, 16, 1'b0);
        put_bit(1'b1, 40);
        chk("idle_after_ferr", busy, 1'b0);

        send(8'h01, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        send(8'hFE, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        put_bit(1'b1, 20);

        put_bit(1'b0, 16);
        put_bit(1'b1, 16);
        put_bit(1'b0, 16);
        put_bit(1'b1, 8);
        chk("pre_reset_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("midrst_dout", rx_dout, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", rx_done, 1'b0);
        put_bit(1'b1, 10);
        reset = 1'b1;
        put_bit(1'b1, 10);
        send(8'h55, 1'b1, 1'b0, 1'b0, 16, 1'b0);
        put_bit(1'b1, 20);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send(8'h07, 1'b1, 1'b1, 1'b0, 16, 1'b0);
        put_bit(1'b1, 20);
        send(8'h07, 1'b1, 1'b0, 1'b1, 16, 1'b0);
        put_bit(1'b1, 20);
        parity_odd = 1'b1;
        send(8'h07, 1'b1, 1'b1, 1'b1, 16, 1'b0);
        put_bit(1'b1, 20);
        parity_odd = 1'b0;
`endif

        half = 1'b1;
        send(8'h5A, 1'b1, 1'b0, 1'b0, 32, 1'b0);
        put_bit(1'b1, 40);
        half = 1'b0;

        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
